// File: rtl/ctc_trigger_cond.sv
// Trigger conditioner feeding z80ctc_top trg0..trg3: per channel, a synchronised/filtered pin or a shared divider tick.
// Define CTC_TRG_RDBK_EN to enable register readback on dout; otherwise dout is tied to 8'hFF.
module ctc_trigger_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_ena,
  input  logic [7:0] din,
  input  logic [2:0] addr,
  input  logic       we,
  input  logic       rd,
  output logic [7:0] dout,
  input  logic [3:0] ext_trg,
  output logic [3:0] trg
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned FLT_W = 4;

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
  logic [7:0]                      cfg_q [NCH];
  logic [7:0]                      cfg_d [NCH];
  logic [7:0]                      div_lo_q, div_lo_d;
  logic [DIV_W-1:0]                div_q, div_d;
  logic [DIV_W-1:0]                div_cnt_q, div_cnt_d;
  logic                            div_en_q, div_en_d;
  logic [FLT_W-1:0]                flt_cnt_q [NCH];
  logic [FLT_W-1:0]                flt_cnt_d [NCH];
  logic [NCH-1:0]                  trg_q, trg_d;

  logic [NCH-1:0]                  s_c;
  logic [FLT_W-1:0]                thr_c [NCH];
  logic [DIV_W-1:0]                reload_c, new_div_c, new_reload_c;
  logic                            tick_c, commit_c;

  // Per-channel conditioned pin level, effective threshold, and divider reload (a zero DIV behaves as 1).
  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      s_c[n]   = sync_q[SYNC_STAGES-1][n] ^ cfg_q[n][1];
      thr_c[n] = cfg_q[n][2] ? cfg_q[n][7:4] : '0;
    end
    reload_c     = (div_q == '0) ? DIV_W'(1) : div_q;
    new_div_c    = DIV_W'({din, div_lo_q});
    new_reload_c = (new_div_c == '0) ? DIV_W'(1) : new_div_c;
    commit_c     = clock_ena && we && (addr == 3'd5);
    tick_c       = div_en_q && (div_cnt_q == '0);
  end

  // Next-state: synchroniser, divider, filters, register writes.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], ext_trg};
    cfg_d     = cfg_q;
    div_lo_d  = div_lo_q;
    div_d     = div_q;
    div_en_d  = div_en_q;
    div_cnt_d = div_cnt_q;
    flt_cnt_d = flt_cnt_q;
    trg_d     = trg_q;

    if (clock_ena) begin
      if (div_en_q) begin
        div_cnt_d = (div_cnt_q == '0) ? reload_c : div_cnt_q - DIV_W'(1);
      end

      for (int unsigned n = 0; n < NCH; n++) begin
        if (cfg_q[n][0]) begin
          trg_d[n]     = tick_c && !commit_c;
          flt_cnt_d[n] = '0;
        end else if (s_c[n] == trg_q[n]) begin
          flt_cnt_d[n] = '0;
        end else if (flt_cnt_q[n] == thr_c[n]) begin
          trg_d[n]     = s_c[n];
          flt_cnt_d[n] = '0;
        end else begin
          flt_cnt_d[n] = flt_cnt_q[n] + FLT_W'(1);
        end
      end

      // Writes land after the events above, so a coincident event sees the old register value.
      if (we) begin
        case (addr)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            cfg_d[addr[1:0]] = din;
            if (din[0] != cfg_q[addr[1:0]][0]) begin
              trg_d[addr[1:0]]     = 1'b0;
              flt_cnt_d[addr[1:0]] = '0;
            end
          end
          3'd4: div_lo_d = din;
          3'd5: begin
            div_d     = new_div_c;
            div_cnt_d = new_reload_c;
          end
          3'd6: div_en_d = din[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      div_lo_q  <= '0;
      div_q     <= '0;
      div_cnt_q <= DIV_W'(1);
      div_en_q  <= 1'b0;
      trg_q     <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        cfg_q[n]     <= '0;
        flt_cnt_q[n] <= '0;
      end
    end else begin
      sync_q    <= sync_d;
      div_lo_q  <= div_lo_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      div_en_q  <= div_en_d;
      trg_q     <= trg_d;
      for (int unsigned n = 0; n < NCH; n++) begin
        cfg_q[n]     <= cfg_d[n];
        flt_cnt_q[n] <= flt_cnt_d[n];
      end
    end
  end

  assign trg = trg_q;

`ifdef CTC_TRG_RDBK_EN
  logic [7:0]  dout_q, dout_d;
  logic [15:0] div_view_c;

  // Readback samples pre-write values, so a write and read together return the old contents.
  always_comb begin
    div_view_c = 16'(div_q);
    dout_d     = dout_q;
    if (clock_ena && rd) begin
      case (addr)
        3'd4:    dout_d = div_view_c[7:0];
        3'd5:    dout_d = div_view_c[15:8];
        3'd6:    dout_d = {7'b0, div_en_q};
        3'd7:    dout_d = {4'b0, trg_q};
        default: dout_d = cfg_q[addr[1:0]];
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= 8'hFF;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  logic unused_rd;
  assign unused_rd = rd;
  assign dout      = 8'hFF;
`endif

endmodule

// File: tb/tb_ctc_trigger_cond.sv
// Bench for ctc_trigger_cond: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the trigger rules.
module tb_ctc_trigger_cond;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DIV_W       = 16;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       clock_ena = 1'b0;
  logic [7:0] din       = 8'h00;
  logic [2:0] addr      = 3'd0;
  logic       we        = 1'b0;
  logic       rd        = 1'b0;
  logic [7:0] dout;
  logic [3:0] ext_trg   = 4'h0;
  logic [3:0] trg;

  int n_checks = 0;
  int n_fail   = 0;
  int ena_per  = 1;
  int ena_ph   = 0;

  ctc_trigger_cond #(.SYNC_STAGES(SYNC_STAGES), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset_n(reset_n), .clock_ena(clock_ena), .din(din), .addr(addr),
    .we(we), .rd(rd), .dout(dout), .ext_trg(ext_trg), .trg(trg)
  );

  always #5 clock = ~clock;

  // Behavioural model: pins seen SYNC_STAGES clocks late, filter as a disagreement run length,
  // divider ticks whenever the enabled-cycle count since the last commit is a multiple of the period.
  logic [7:0] m_cfg [4];
  logic [7:0] m_lo;
  logic [15:0] m_div;
  logic       m_den;
  int         m_en_cnt;
  int         m_run [4];
  logic [3:0] m_hist [$];
  logic [3:0] m_trg  = 4'h0;
  logic [7:0] m_dout = 8'hFF;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_cfg[n] = 8'h00;
      m_run[n] = 0;
    end
    m_lo = 8'h00; m_div = 16'h0000; m_den = 1'b0; m_en_cnt = 0;
    m_trg = 4'h0; m_dout = 8'hFF;
    m_hist.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_hist.push_back(4'h0);
  endtask

  task automatic model_step();
    logic [3:0] synced, nxt;
    logic       tick, commit, s;
    logic [1:0] a;
    int         p, thr;
    synced = m_hist.pop_front();
    m_hist.push_back(ext_trg);
    if (!clock_ena) return;
    nxt    = m_trg;
    commit = we && (addr == 3'd5);
    tick   = 1'b0;
    p      = (m_div == 16'h0000) ? 2 : int'(m_div) + 1;
    if (m_den && !commit) begin
      m_en_cnt++;
      tick = ((m_en_cnt % p) == 0);
    end
    for (int n = 0; n < 4; n++) begin
      if (m_cfg[n][0]) begin
        nxt[n] = tick;
        m_run[n] = 0;
      end else begin
        s   = synced[n] ^ m_cfg[n][1];
        thr = m_cfg[n][2] ? int'(m_cfg[n][7:4]) : 0;
        if (s != m_trg[n]) begin
          m_run[n]++;
          if (m_run[n] > thr) begin
            nxt[n]   = s;
            m_run[n] = 0;
          end
        end else begin
          m_run[n] = 0;
        end
      end
    end
`ifdef CTC_TRG_RDBK_EN
    if (rd) begin
      case (addr)
        3'd4:    m_dout = m_div[7:0];
        3'd5:    m_dout = m_div[15:8];
        3'd6:    m_dout = {7'b0, m_den};
        3'd7:    m_dout = {4'b0, m_trg};
        default: m_dout = m_cfg[addr[1:0]];
      endcase
    end
`endif
    if (we) begin
      a = addr[1:0];
      if (addr < 3'd4) begin
        if (din[0] != m_cfg[a][0]) begin
          nxt[a]   = 1'b0;
          m_run[a] = 0;
        end
        m_cfg[a] = din;
      end else if (addr == 3'd4) begin
        m_lo = din;
      end else if (addr == 3'd5) begin
        m_div    = {din, m_lo};
        m_en_cnt = 0;
      end else if (addr == 3'd6) begin
        m_den = din[0];
      end
    end
    m_trg = nxt;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("trg_vs_model", {4'b0, trg}, {4'b0, m_trg});
    chk("dout_vs_model", dout, m_dout);
  end

  // Advance one clock, then drive the clock_ena value for the next edge.
  task automatic step();
    @(posedge clock);
    #2;
    we = 1'b0;
    rd = 1'b0;
    if (ena_per == 0) begin
      clock_ena = ($urandom_range(0, 3) != 0);
    end else begin
      ena_ph    = (ena_ph + 1) % ena_per;
      clock_ena = (ena_ph == 0);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    for (int i = 0; i < 8 && !clock_ena; i++) step();
    we = 1'b1; addr = a; din = d;
    step();
  endtask

  task automatic wait_rise(input int ch, input int limit, output bit ok);
    logic prev;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      prev = trg[ch];
      step();
      if (!prev && trg[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rise_ch%0d: no rising edge within %0d clocks", ch, limit);
    end
  endtask

  // From a rising edge of trg[2], count high clocks across four divider periods.
  task automatic measure(input int pe, input int per, input string name);
    bit ok;
    int highs, len;
    len = 4 * pe * per;
    wait_rise(2, 200, ok);
    if (ok) begin
      highs = 0;
      for (int i = 0; i < len; i++) begin
        if (trg[2]) highs++;
        step();
      end
      chk({name, "_high_clocks"}, 8'(highs), 8'(4 * per));
      chk({name, "_next_rise"}, 8'(trg[2]), 8'h01);
    end
  endtask

  initial begin
    int highs;
    clock_ena = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("reset_trg", {4'b0, trg}, 8'h00);
    chk("reset_dout", dout, 8'hFF);

    // Unfiltered pin latency.
    ext_trg[0] = 1'b1;
    step(); step();
    chk("t2_before_latency", 8'(trg[0]), 8'h00);
    step();
    chk("t2_latency", 8'(trg[0]), 8'h01);

    // Filter threshold 15: short pulse blocked, long pulse passes after 16 enabled cycles.
    wr(3'd1, 8'hF4);
    ext_trg[1] = 1'b1;
    repeat (10) step();
    ext_trg[1] = 1'b0;
    highs = 0;
    repeat (30) begin
      step();
      if (trg[1]) highs++;
    end
    chk("t3_glitch_blocked", 8'(highs), 8'h00);
    ext_trg[1] = 1'b1;
    repeat (17) step();
    chk("t3_before_thr", 8'(trg[1]), 8'h00);
    step();
    chk("t3_after_thr", 8'(trg[1]), 8'h01);
    repeat (2) step();
    ext_trg[1] = 1'b0;
    repeat (40) step();

    // Divider DIV=3 at full rate and at one enable in three.
    wr(3'd4, 8'h03); wr(3'd5, 8'h00); wr(3'd2, 8'h01); wr(3'd6, 8'h01);
    measure(4, 1, "t4_div3");
    ena_per = 3; ena_ph = 0;
    measure(4, 3, "t4_div3_ena3");
    ena_per = 1; ena_ph = 0;

    // DIV=0 behaves as period 2; a mid-count commit restarts the count.
    wr(3'd4, 8'h00); wr(3'd5, 8'h00);
    measure(2, 1, "t5_div0");
    wr(3'd4, 8'h05);
    repeat (3) step();
    wr(3'd5, 8'h00);
    chk("t5_commit_clears", 8'(trg[2]), 8'h00);
    highs = 0;
    repeat (5) begin
      step();
      if (trg[2]) highs++;
    end
    chk("t5_quiet_after_commit", 8'(highs), 8'h00);
    step();
    chk("t5_first_tick", 8'(trg[2]), 8'h01);

    // Invert then switch channel 3 to the divider.
    wr(3'd3, 8'h02);
    chk("t6_write_cycle", 8'(trg[3]), 8'h00);
    step();
    chk("t6_invert", 8'(trg[3]), 8'h01);
    wr(3'd3, 8'h03);
    chk("t6_switch_to_div", 8'(trg[3]), 8'h00);

    // Drive all triggers high, then assert reset between clock edges.
    ext_trg = 4'h0;
    repeat (10) step();
    wr(3'd0, 8'h02); wr(3'd1, 8'h02); wr(3'd2, 8'h02); wr(3'd3, 8'h02);
    repeat (3) step();
    chk("t1_all_high", {4'b0, trg}, 8'h0F);
    reset_n = 1'b0;
    #1;
    chk("t1_async_trg", {4'b0, trg}, 8'h00);
    chk("t1_async_dout", dout, 8'hFF);
    repeat (2) step();
    reset_n = 1'b1;
    step();
`ifdef CTC_TRG_RDBK_EN
    for (int a = 0; a < 4; a++) begin
      rd = 1'b1; addr = 3'(a);
      step();
      chk("t1_cfg_readback", dout, 8'h00);
    end
`else
    rd = 1'b1; addr = 3'd0;
    step();
    chk("t1_dout_constant", dout, 8'hFF);
`endif

    // Randomized traffic with a reset in the middle.
    ena_per = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c == 2000) reset_n = 1'b0;
      if (c == 2003) reset_n = 1'b1;
      if ($urandom_range(0, 15) == 0) ext_trg = ext_trg ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        we   = 1'b1;
        addr = 3'($urandom_range(0, 7));
        case (addr)
          3'd4:    din = 8'($urandom_range(0, 9));
          3'd5:    din = 8'($urandom_range(0, 1));
          3'd6:    din = 8'($urandom_range(0, 1));
          default: din = {2'b00, 6'($urandom)};
        endcase
        if ($urandom_range(0, 3) == 0) rd = 1'b1;
      end else if ($urandom_range(0, 5) == 0) begin
        rd   = 1'b1;
        addr = 3'($urandom_range(0, 7));
      end
    end
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
